// File: rtl/bram_stream_reader_if.sv
// Valid/ready read-data stream between bram_stream_reader and its consumer.
// Optional m_last tag is present when BRAM_STREAM_READER_TLAST_EN is defined.
interface bram_stream_reader_if #(
    parameter int C_DATA_WIDTH = 32
);
    logic [C_DATA_WIDTH-1:0] data;
    logic                    valid;
    logic                    ready;
`ifdef BRAM_STREAM_READER_TLAST_EN
    logic                    last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
`else
    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
`endif
endinterface

// File: rtl/bram_stream_reader.sv
// Job-driven reader for a pipelined, rden-gated BRAM read port; streams words out with backpressure.
// Optional feature macro: BRAM_STREAM_READER_TLAST_EN (adds m_last on the final beat).
module bram_stream_reader #(
    parameter int  C_RAM_RD_WIDTH  = 32,
    parameter int  C_RAM_RD_DEPTH  = 512,
    parameter int  C_RD_LATENCY    = 3,
    localparam int C_CLG2_RD_DEPTH = $clog2(C_RAM_RD_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [C_CLG2_RD_DEPTH-1:0] base_addr_i,
    input  logic [C_CLG2_RD_DEPTH:0]   num_words_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [C_CLG2_RD_DEPTH-1:0] ram_rdAddr_o,
    output logic                       ram_rden_o,
    input  logic [C_RAM_RD_WIDTH-1:0]  ram_dout_i,
    bram_stream_reader_if.master       m_if
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_RUN   | issuing reads, one per enabled cycle
    // S_DRAIN | all reads issued, flushing the RAM pipeline
    // S_DONE  | done pulse, then back to idle
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [C_CLG2_RD_DEPTH:0] C_ONE = (C_CLG2_RD_DEPTH+1)'(1);

    state_t                     state_q;
    logic                       busy_q;
    logic                       done_q;
    logic [C_CLG2_RD_DEPTH-1:0] addr_q;
    logic [C_CLG2_RD_DEPTH:0]   rem_q;
    logic [C_RD_LATENCY-1:0]    vld_q;
    logic [C_RD_LATENCY-1:0]    vld_d;
    logic                       vld_in;
    logic                       m_valid;
    logic                       rden;

    assign m_valid = vld_q[C_RD_LATENCY-1];
    assign vld_in  = (state_q == S_RUN) && (rem_q != '0);
    // Holding rden low during a stall freezes every RAM stage, so m_data stays put.
    assign rden    = (!m_valid || m_if.ready) && ((state_q == S_RUN) || (|vld_q));

    always_comb begin
        vld_d = vld_q;
        if (rden) begin
            for (int i = C_RD_LATENCY-1; i > 0; i--) begin
                vld_d[i] = vld_q[i-1];
            end
            vld_d[0] = vld_in;
        end
    end

`ifdef BRAM_STREAM_READER_TLAST_EN
    logic [C_RD_LATENCY-1:0] last_q;
    logic [C_RD_LATENCY-1:0] last_d;

    always_comb begin
        last_d = last_q;
        if (rden) begin
            for (int i = C_RD_LATENCY-1; i > 0; i--) begin
                last_d[i] = last_q[i-1];
            end
            last_d[0] = (state_q == S_RUN) && (rem_q == C_ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end

    assign m_if.last = last_q[C_RD_LATENCY-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            vld_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (num_words_i != '0) begin
                            addr_q  <= base_addr_i;
                            rem_q   <= num_words_i;
                            state_q <= S_RUN;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (rden) begin
                        addr_q <= addr_q + 1'b1;
                        rem_q  <= rem_q - C_ONE;
                        if (rem_q == C_ONE) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (vld_d == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Zero-length jobs arrive here with done still low and pulse it one cycle later.
                    if (done_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign ram_rdAddr_o = addr_q;
    assign ram_rden_o   = rden;
    assign m_if.data    = ram_dout_i;
    assign m_if.valid   = m_valid;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a 3-stage rden-gated BRAM read model.
// Build with BRAM_STREAM_READER_TLAST_EN defined to exercise m_last.
module tb_bram_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  base_addr;
    logic [9:0]  num_words;
    logic        busy;
    logic        done;
    logic [8:0]  ram_rdAddr;
    logic        ram_rden;
    logic [31:0] ram_dout;

    int n_cmp;
    int n_err;

    bram_stream_reader_if #(.C_DATA_WIDTH(32)) m_if ();

    bram_stream_reader #(
        .C_RAM_RD_WIDTH (32),
        .C_RAM_RD_DEPTH (512),
        .C_RD_LATENCY   (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .num_words_i  (num_words),
        .busy_o       (busy),
        .done_o       (done),
        .ram_rdAddr_o (ram_rdAddr),
        .ram_rden_o   (ram_rden),
        .ram_dout_i   (ram_dout),
        .m_if         (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [512];
    logic [31:0] s1, s2, s3;
    always @(posedge clk) begin
        if (ram_rden) begin
            s1 <= mem[ram_rdAddr];
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign ram_dout = s3;

    task automatic start_job(input logic [8:0] b, input logic [9:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || ram_rden !== 1'b0 || ram_rdAddr !== 9'd0 || m_if.valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs got busy=%b done=%b rden=%b addr=%0d valid=%b want all 0",
                     busy, done, ram_rden, ram_rdAddr, m_if.valid);
        end
`ifdef BRAM_STREAM_READER_TLAST_EN
        n_cmp++;
        if (m_if.last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_last got %b want 0", m_if.last);
        end
`endif
    endtask

    task automatic test_basic();
        int first_k, done_k, beats;
        first_k = -1; done_k = -1; beats = 0;
        m_if.ready = 1'b1;
        start_job(9'd0, 10'd8);
        n_cmp++;
        if (ram_rden !== 1'b1 || ram_rdAddr !== 9'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_first_issue got rden=%b addr=%0d busy=%b want 1/0/1", ram_rden, ram_rdAddr, busy);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (m_if.valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                n_cmp++;
                if (m_if.data !== 32'(beats) || k != first_k + beats) begin
                    n_err++;
                    $display("FAIL basic_data cycle %0d got %0d want %0d (contiguous)", k, m_if.data, beats);
                end
                beats++;
            end
            if (done === 1'b1 && done_k < 0) begin
                done_k = k;
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_busy_at_done got %b want 0", busy);
                end
            end
        end
        n_cmp++;
        if (first_k != 4) begin
            n_err++;
            $display("FAIL basic_latency got cycle %0d want 4", first_k);
        end
        n_cmp++;
        if (beats != 8) begin
            n_err++;
            $display("FAIL basic_beats got %0d want 8", beats);
        end
        n_cmp++;
        if (done_k != 12) begin
            n_err++;
            $display("FAIL basic_done_cycle got %0d want 12", done_k);
        end
    endtask

    task automatic test_backpressure();
        logic pat [6];
        int   beats, stalls;
        logic done_seen;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        beats = 0; stalls = 0; done_seen = 1'b0;
        start_job(9'd4, 10'd6);
        for (int k = 0; k < 80 && !done_seen; k++) begin
            m_if.ready = pat[k % 6];
            @(negedge clk);
            if (m_if.valid === 1'b1) begin
                n_cmp++;
                if (m_if.data !== 32'(4 + beats)) begin
                    n_err++;
                    $display("FAIL bp_data got %0d want %0d", m_if.data, 4 + beats);
                end
                if (m_if.ready) begin
                    beats++;
                end else begin
                    stalls++;
                    n_cmp++;
                    if (ram_rden !== 1'b0) begin
                        n_err++;
                        $display("FAIL bp_rden_stall got %b want 0", ram_rden);
                    end
                end
            end
            if (done === 1'b1) begin
                done_seen = 1'b1;
                n_cmp++;
                if (beats != 6) begin
                    n_err++;
                    $display("FAIL bp_beats got %0d want 6", beats);
                end
            end
            @(posedge clk); #1;
        end
        m_if.ready = 1'b1;
        n_cmp++;
        if (!done_seen || stalls == 0) begin
            n_err++;
            $display("FAIL bp_done_and_stalls got done=%b stalls=%0d want done=1 stalls>0", done_seen, stalls);
        end
    endtask

    task automatic test_wrap();
        int beats, exp_a;
        beats = 0;
        m_if.ready = 1'b1;
        start_job(9'd510, 10'd4);
        for (int k = 1; k <= 16; k++) begin
            if (k <= 4) begin
                exp_a = (510 + k - 1) % 512;
                n_cmp++;
                if (ram_rden !== 1'b1 || ram_rdAddr !== 9'(exp_a)) begin
                    n_err++;
                    $display("FAIL wrap_addr got rden=%b addr=%0d want 1/%0d", ram_rden, ram_rdAddr, exp_a);
                end
            end
            @(negedge clk);
            if (m_if.valid === 1'b1) begin
                exp_a = (510 + beats) % 512;
                n_cmp++;
                if (m_if.data !== 32'(exp_a)) begin
                    n_err++;
                    $display("FAIL wrap_data got %0d want %0d", m_if.data, exp_a);
                end
                beats++;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (beats != 4) begin
            n_err++;
            $display("FAIL wrap_beats got %0d want 4", beats);
        end
    endtask

    task automatic test_zero_len();
        start_job(9'd5, 10'd0);
        // start sampled at the end of cycle T; cycle k below is T+k, done expected in T+2
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ram_rden !== 1'b0 || done !== (k == 2) || busy !== (k == 1) || m_if.valid !== 1'b0) begin
                n_err++;
                $display("FAIL zero_len cycle %0d got rden=%b done=%b busy=%b valid=%b want 0/%b/%b/0",
                         k, ram_rden, done, busy, m_if.valid, k == 2, k == 1);
            end
        end
    endtask

    task automatic test_ignored_start();
        int beats, dones;
        beats = 0; dones = 0;
        m_if.ready = 1'b1;
        start_job(9'd100, 10'd4);
        start = 1'b1; base_addr = 9'd200; num_words = 10'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (m_if.valid === 1'b1) begin
                n_cmp++;
                if (m_if.data !== 32'(100 + beats)) begin
                    n_err++;
                    $display("FAIL ign_data got %0d want %0d", m_if.data, 100 + beats);
                end
                beats++;
            end
            if (done === 1'b1) dones++;
        end
        n_cmp++;
        if (beats != 4 || dones != 1 || busy !== 1'b0 || ram_rden !== 1'b0) begin
            n_err++;
            $display("FAIL ign_summary got beats=%0d dones=%0d busy=%b rden=%b want 4/1/0/0", beats, dones, busy, ram_rden);
        end
    endtask

    task automatic test_reset_mid();
        int beats, dones;
        beats = 0; dones = 0;
        m_if.ready = 1'b1;
        start_job(9'd0, 10'd16);
        for (int k = 0; k < 30 && beats < 3; k++) begin
            @(negedge clk);
            if (m_if.valid === 1'b1) beats++;
        end
        n_cmp++;
        if (beats != 3) begin
            n_err++;
            $display("FAIL rst_mid_prebeats got %0d want 3", beats);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (m_if.valid !== 1'b0 || busy !== 1'b0 || ram_rden !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_async got valid=%b busy=%b rden=%b done=%b want 0/0/0/0",
                     m_if.valid, busy, ram_rden, done);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done === 1'b1 || m_if.valid === 1'b1) dones++;
        end
        rst_n = 1'b1;
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL rst_mid_hold got %0d active cycles want 0", dones);
        end
        beats = 0; dones = 0;
        start_job(9'd0, 10'd2);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (m_if.valid === 1'b1) begin
                n_cmp++;
                if (m_if.data !== 32'(beats)) begin
                    n_err++;
                    $display("FAIL rst_mid_newjob_data got %0d want %0d", m_if.data, beats);
                end
                beats++;
            end
            if (done === 1'b1) dones++;
        end
        n_cmp++;
        if (beats != 2 || dones != 1) begin
            n_err++;
            $display("FAIL rst_mid_newjob got beats=%0d dones=%0d want 2/1", beats, dones);
        end
    endtask

`ifdef BRAM_STREAM_READER_TLAST_EN
    task automatic test_tlast();
        int beats;
        beats = 0;
        m_if.ready = 1'b1;
        start_job(9'd0, 10'd5);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (m_if.valid === 1'b1) begin
                n_cmp++;
                if (m_if.last !== (beats == 4)) begin
                    n_err++;
                    $display("FAIL tlast5 beat %0d got %b want %b", beats, m_if.last, beats == 4);
                end
                beats++;
            end
        end
        beats = 0;
        start_job(9'd7, 10'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m_if.valid === 1'b1) begin
                n_cmp++;
                if (m_if.last !== 1'b1 || m_if.data !== 32'd7) begin
                    n_err++;
                    $display("FAIL tlast1 got last=%b data=%0d want 1/7", m_if.last, m_if.data);
                end
                beats++;
            end
        end
        n_cmp++;
        if (beats != 1) begin
            n_err++;
            $display("FAIL tlast1_beats got %0d want 1", beats);
        end
    endtask
`endif

    initial begin
        n_cmp = 0; n_err = 0;
        for (int i = 0; i < 512; i++) mem[i] = 32'(i);
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        m_if.ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_ignored_start();
        test_reset_mid();
`ifdef BRAM_STREAM_READER_TLAST_EN
        test_tlast();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
